uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Oversampling UART receiver: the receive-side counterpart of the UART TX path. It detects a start bit on the asynchronous serial line, takes a majority vote of three samples per bit, and deserializes `WIDTH` data bits LSB-first. It then checks optional parity and the stop bit, and delivers a parallel word with a one-cycle valid strobe. It sits in the UART RX clock domain, which runs at PRESCALE × baud, and feeds the RX-side data synchronizer and system controller.

## Interface
- `WIDTH`, 8: number of data bits per frame.
- `PRESC_W`, 6: width of the `PRESCALE` port.
- `CLK`  in  1: RX oversampling clock, PRESCALE × baud.
- `RST`  in  1: reset, asynchronous, active-low.
- `RX_IN`  in  1: serial line, idle high. Already synchronized upstream.
- `PRESCALE`  in  PRESC_W: oversampling ratio. Legal values are 8, 16 and 32. Other values give undefined behaviour. Must be static while a frame is in progress.
- `PAR_EN`  in  1: 1 means the frame carries a parity bit after the data bits.
- `PAR_TYP`  in  1: 0 selects even parity, 1 selects odd.
- `P_DATA`  out  WIDTH: received word. Held stable until the next frame completes.
- `DATA_VALID`  out  1: one-cycle pulse. `P_DATA` is valid and error-free in that cycle.
- `PAR_ERR`  out  1: parity mismatch on the current or last frame.
- `STP_ERR`  out  1: stop bit sampled as 0 on the current or last frame.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, CHK.
- Edge counter `edge_cnt`:
  - Counts 0..PRESCALE-1 within each bit.
  - Wraps to 0 at PRESCALE-1, and the bit counter `bit_cnt` increments on the wrap.
  - Both counters are held at 0 in IDLE and CHK.
- Sampling:
  - Let h = PRESCALE>>1. Samples are taken at edge_cnt = h-1, h and h+1.
  - The sampled bit is the 2-of-3 majority, registered at edge_cnt = h+2.
- IDLE → START when RX_IN = 0.
- START:
  - If the sampled start bit is 1 (a glitch), go to IDLE at the end of the bit. No flags change.
  - Otherwise go to DATA at edge_cnt = PRESCALE-1.
- DATA:
  - Each sampled bit shifts into the shift register MSB side, right-shift, so the first bit lands in bit 0 after WIDTH shifts.
  - After WIDTH bits, go to PARITY if PAR_EN = 1, else STOP.
- PARITY: compute the expected parity, which is the XOR of all data bits, XORed with PAR_TYP. `PAR_ERR` is set at the sample decision cycle if the sampled bit does not match.
- STOP: `STP_ERR` is set at the sample decision cycle if the sampled bit is 0. At edge_cnt = PRESCALE-1 → CHK.
- CHK:
  - Lasts one cycle.
  - If PAR_ERR = 0 and STP_ERR = 0: load `P_DATA` from the shift register and pulse `DATA_VALID`.
  - Next state is START if RX_IN = 0, else IDLE.
- Errored frames never update `P_DATA` and never pulse `DATA_VALID`.
- `PAR_ERR` and `STP_ERR` are cleared on the IDLE → START or CHK → START transition.
- Reset values, including mid-frame: FSM in IDLE, all counters 0, shift register 0, `P_DATA` = 0, `DATA_VALID` = 0, `PAR_ERR` = 0, `STP_ERR` = 0. A partial frame is discarded. Reception resumes on the next falling edge after reset release.

## Timing
- Start detection happens in the first cycle RX_IN is low while in IDLE. edge_cnt = 0 is the cycle after detection.
- Frame length is N = 1 + WIDTH + PAR_EN + 1 bits.
- `DATA_VALID` rises exactly N·PRESCALE + 1 cycles after the start-detect cycle, and lasts one cycle.
- `P_DATA` updates in the same cycle `DATA_VALID` rises.
- Error flags become visible the cycle after the decision edge of the parity bit or stop bit.
- Back-to-back frames with zero idle bits are supported: CHK → START with no lost cycle.

## Structure
- Shared package `uart_pkg`:
  - State enum for the RX FSM.
  - Parity-type constants PAR_EVEN = 0 and PAR_ODD = 1, shared with the TX parity calculator.
  - Legal PRESCALE constants.
- One sub-module, `uart_rx_sampler`. It contains the three-sample capture and majority vote, with inputs `edge_cnt`, `PRESCALE`, `RX_IN` and outputs `sampled_bit` and `sample_done`.
- The FSM, counters, deserializer and checkers stay in `uart_rx_core`.

## Test plan
- PRESCALE = 8, PAR_EN = 1, PAR_TYP = 0, frame 0xA5 with parity 0 → one `DATA_VALID` pulse at cycle 11·8+1 after the start, `P_DATA` = 0xA5, no error flags.
- Same configuration, frame 0x3C sent with parity bit 1 → `PAR_ERR` = 1, no `DATA_VALID`, `P_DATA` keeps its old value.
- PRESCALE = 16, PAR_EN = 0, frame 0x81 with stop bit 0 → `STP_ERR` = 1, no `DATA_VALID`. The next good frame 0x7E clears the flag and gives `P_DATA` = 0x7E.
- RX_IN low pulse of 2 cycles at PRESCALE = 8 → FSM returns to IDLE, no flags, no `DATA_VALID`.
- PRESCALE = 32, PAR_TYP = 1, frames 0x00 and 0xFF sent with zero idle gap, plus a single-cycle flip at edge h on every bit → two `DATA_VALID` pulses carrying 0x00 then 0xFF. The majority vote masks the flips.
- RST asserted during DATA of frame 0x55, then frame 0x12 sent → all outputs 0 while reset is asserted, followed by a single `DATA_VALID` with `P_DATA` = 0x12.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the RX/TX paths
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_CHK
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - three-point mid-bit capture with 2-of-3 majority vote
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               RX_IN,
  output logic               sampled_bit,
  output logic               sample_done
);

  logic [PRESC_W-1:0] w_half;
  logic [2:0]         r_smp;

  assign w_half = PRESCALE >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_smp <= 3'b000;
    end else begin
      if (edge_cnt == w_half - PRESC_W'(1)) r_smp[0] <= RX_IN;
      if (edge_cnt == w_half)               r_smp[1] <= RX_IN;
      if (edge_cnt == w_half + PRESC_W'(1)) r_smp[2] <= RX_IN;
    end
  end

  // All three samples are settled by h+2; the core registers the vote on this edge.
  assign sample_done = (edge_cnt == w_half + PRESC_W'(2));
  assign sampled_bit = maj3(r_smp[0], r_smp[1], r_smp[2]);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampling UART receiver: FSM, counters, deserializer, checkers
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] PRESCALE,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [WIDTH-1:0]   P_DATA,
  output logic               DATA_VALID,
  output logic               PAR_ERR,
  output logic               STP_ERR
);

  localparam int BIT_W = $clog2(WIDTH + 4);

  rx_state_t          r_state;
  logic [PRESC_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_p_data;
  logic               r_data_valid;
  logic               r_par_err;
  logic               r_stp_err;
  logic               r_glitch;

  logic w_sampled_bit;
  logic w_sample_done;
  logic w_last_edge;
  logic w_par_exp;
  logic w_active;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .edge_cnt    (r_edge_cnt),
    .PRESCALE    (PRESCALE),
    .RX_IN       (RX_IN),
    .sampled_bit (w_sampled_bit),
    .sample_done (w_sample_done)
  );

  assign w_last_edge = (r_edge_cnt == PRESCALE - PRESC_W'(1));
  assign w_par_exp   = (^r_shift) ^ (PAR_TYP == PAR_ODD);
  assign w_active    = (r_state != ST_IDLE) && (r_state != ST_CHK);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_IDLE;
      r_edge_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_glitch     <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;

      if (w_active) begin
        if (w_last_edge) begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
        end else begin
          r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
        end
      end

      case (r_state)
        ST_IDLE: begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          if (!RX_IN) begin
            r_state   <= ST_START;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
            r_glitch  <= 1'b0;
          end
        end
        ST_START: begin
          if (w_sample_done && w_sampled_bit) r_glitch <= 1'b1;
          if (w_last_edge) begin
            if (r_glitch) begin
              r_state   <= ST_IDLE;
              r_bit_cnt <= '0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_sample_done) r_shift <= {w_sampled_bit, r_shift[WIDTH-1:1]};
          if (w_last_edge && (r_bit_cnt == BIT_W'(WIDTH)))
            r_state <= PAR_EN ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          if (w_sample_done) r_par_err <= (w_sampled_bit != w_par_exp);
          if (w_last_edge) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (w_sample_done) r_stp_err <= !w_sampled_bit;
          // Load on the way into CHK so the registered strobe lines up with the CHK cycle.
          if (w_last_edge) begin
            r_state   <= ST_CHK;
            r_bit_cnt <= '0;
            if (!r_par_err && !r_stp_err) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
        end
        ST_CHK: begin
          r_edge_cnt <= '0;
          r_bit_cnt  <= '0;
          if (!RX_IN) begin
            r_state   <= ST_START;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
            r_glitch  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign P_DATA     = r_p_data;
  assign DATA_VALID = r_data_valid;
  assign PAR_ERR    = r_par_err;
  assign STP_ERR    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core
module tb_uart_rx_core;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 6;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic               RX_IN = 1'b1;
  logic [PRESC_W-1:0] PRESCALE = 6'd8;
  logic               PAR_EN = 1'b1;
  logic               PAR_TYP = 1'b0;
  logic [WIDTH-1:0]   P_DATA;
  logic               DATA_VALID;
  logic               PAR_ERR;
  logic               STP_ERR;

  uart_rx_core #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got DATA_VALID=1 P_DATA=0x%0h, expected no pulse (cycle %0d)",
                 P_DATA, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("p_data", {24'd0, P_DATA}, {24'd0, mon_e.data});
        check("valid_par_err", {31'd0, PAR_ERR}, 32'd0);
        check("valid_stp_err", {31'd0, STP_ERR}, 32'd0);
        if (mon_e.due >= 0) check("valid_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1 RX_IN = 1'b1;
    end
  endtask

  task automatic drive_bit(input logic b, input int flip_off);
    for (int i = 0; i < int'(PRESCALE); i++) begin
      @(posedge CLK);
      #1 RX_IN = (i == flip_off) ? ~b : b;
    end
  endtask

  // Called #1 after a posedge, so the start bit's first cycle is cyc+1.
  task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                            input int flip_off, input bit good, input bit timed);
    exp_t e;
    int   nbits;
    nbits  = 1 + WIDTH + int'(PAR_EN) + 1;
    e.data = data;
    e.due  = timed ? (cyc + 1 + nbits * int'(PRESCALE) + 1) : -1;
    if (good) exp_q.push_back(e);
    drive_bit(1'b0, flip_off);
    for (int i = 0; i < WIDTH; i++) drive_bit(data[i], flip_off);
    if (PAR_EN) drive_bit(par_bit, flip_off);
    drive_bit(stop_bit, flip_off);
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge CLK);
      n++;
    end
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d DATA_VALID pulses missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] pd, input logic pe, input logic se);
    check({tag, "_p_data"},  {24'd0, P_DATA}, {24'd0, pd});
    check({tag, "_par_err"}, {31'd0, PAR_ERR}, {31'd0, pe});
    check({tag, "_stp_err"}, {31'd0, STP_ERR}, {31'd0, se});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    idle(3);
    check_outs("reset", 8'h00, 1'b0, 1'b0);
    check("reset_valid", {31'd0, DATA_VALID}, 32'd0);
    RST = 1'b1;
    idle(4);

    // Good frame, then a parity-error frame that must not disturb P_DATA
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b1, 1'b1);
    idle(4);
    drain("frame_a5", 50);
    check_outs("a5", 8'hA5, 1'b0, 1'b0);

    send_frame(8'h3C, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    idle(4);
    check_outs("par_err", 8'hA5, 1'b1, 1'b0);

    // Stop-bit error, then a good frame that clears the flag
    PRESCALE = 6'd16; PAR_EN = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    idle(4);
    check_outs("stp_err", 8'hA5, 1'b0, 1'b1);

    send_frame(8'h7E, 1'b0, 1'b1, -1, 1'b1, 1'b1);
    idle(4);
    drain("frame_7e", 50);
    check_outs("7e", 8'h7E, 1'b0, 1'b0);

    // Two-cycle glitch must be rejected; a following frame must still time correctly
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    @(posedge CLK); #1 RX_IN = 1'b0;
    @(posedge CLK); #1 RX_IN = 1'b0;
    idle(20);
    check_outs("glitch", 8'h7E, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b1, 1'b1);
    idle(4);
    drain("frame_5a", 50);
    check_outs("5a", 8'h5A, 1'b0, 1'b0);

    // Back-to-back frames with a one-cycle flip inside every bit
    PRESCALE = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    send_frame(8'h00, 1'b1, 1'b1, 17, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1, 17, 1'b1, 1'b0);
    idle(8);
    drain("frames_b2b", 100);
    check_outs("b2b", 8'hFF, 1'b0, 1'b0);

    // Reset in the middle of a frame discards it
    PRESCALE = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    RST = 1'b0;
    idle(2);
    check_outs("mid_reset", 8'h00, 1'b0, 1'b0);
    check("mid_reset_valid", {31'd0, DATA_VALID}, 32'd0);
    RST = 1'b1;
    idle(4);
    send_frame(8'h12, 1'b0, 1'b1, -1, 1'b1, 1'b1);
    idle(4);
    drain("frame_12", 50);
    check_outs("12", 8'h12, 1'b0, 1'b0);

    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
